// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the BCD stopwatch.
// Digit values, FSM state encoding and the decade increment helper.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2,
    LAP     = 2'd3
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX  = 4'd9;
  localparam bcd_t BCD_ZERO = 4'd0;

  // 9 and any illegal code (10-15) both roll to zero.
  function automatic bcd_t bcd_inc(input bcd_t d);
    return (d >= BCD_MAX) ? BCD_ZERO : d + 4'd1;
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_digit.sv
// One decade (0-9) counter of the stopwatch digit chain.
// Flags at_max so the top can build the carry chain.
module bcd_digit
  import stopwatch_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output bcd_t digit,
  output logic at_max
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digit <= BCD_ZERO;
    end else if (clr) begin
      digit <= BCD_ZERO;
    end else if (en) begin
      digit <= bcd_inc(digit);
    end
  end

  assign at_max = (digit == BCD_MAX);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: run/pause/lap FSM, tick prescaler,
// BCD digit chain, lap freeze register and sticky overflow.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start_stop,
  input  logic                clear,
  input  logic                lap,
  output logic [4*DIGITS-1:0] count,
  output logic [4*DIGITS-1:0] display,
  output logic                running,
  output logic                overflow
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  state_t              state;
  state_t              state_nx;
  logic [PW-1:0]       pre;
  logic                cnt_en;
  logic                tick;
  logic                lap_take;
  logic [4*DIGITS-1:0] lap_q;
  logic [DIGITS-1:0]   at_max;
  logic [DIGITS:0]     carry;

  // Counting is gated by the current state, not the next one.
  assign cnt_en  = (state == RUNNING) || (state == LAP);
  assign tick    = cnt_en && (pre == PRE_LAST);
  assign running = cnt_en;

  // Priority: clear > start_stop > lap.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (!clear && start_stop) state_nx = RUNNING;
      end
      RUNNING: begin
        if (clear)           state_nx = IDLE;
        else if (start_stop) state_nx = PAUSED;
        else if (lap)        state_nx = LAP;
      end
      LAP: begin
        if (clear)           state_nx = IDLE;
        else if (start_stop) state_nx = PAUSED;
        else if (lap)        state_nx = RUNNING;
      end
      PAUSED: begin
        if (clear)           state_nx = IDLE;
        else if (start_stop) state_nx = RUNNING;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre <= '0;
    end else if (clear || state == IDLE) begin
      pre <= '0;
    end else if (cnt_en) begin
      pre <= tick ? '0 : pre + PW'(1);
    end
  end

  assign carry[0] = tick;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit u_digit (
      .clk    (clk),
      .reset  (reset),
      .clr    (clear),
      .en     (carry[i]),
      .digit  (count[4*i +: 4]),
      .at_max (at_max[i])
    );
    assign carry[i+1] = carry[i] & at_max[i];
  end

  // Capture sees the pre-increment count when a tick coincides.
  assign lap_take = (state == RUNNING) && lap
                 && !clear && !start_stop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lap_q <= '0;
    end else if (clear) begin
      lap_q <= '0;
    end else if (lap_take) begin
      lap_q <= count;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (clear) begin
      overflow <= 1'b0;
    end else if (carry[DIGITS]) begin
      overflow <= 1'b1;
    end
  end

  assign display = (state == LAP) ? lap_q : count;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with DIGITS=2, TICK_DIV=4.
// Vector table plus hand sequences for overflow and async reset.
module tb_stopwatch_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_stop;
  logic       clear;
  logic       lap;
  logic [7:0] count;
  logic [7:0] display;
  logic       running;
  logic       overflow;

  int total = 0;
  int passes = 0;

  always #5 clk = ~clk;

  stopwatch_ctrl #(
    .DIGITS   (2),
    .TICK_DIV (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start_stop (start_stop),
    .clear      (clear),
    .lap        (lap),
    .count      (count),
    .display    (display),
    .running    (running),
    .overflow   (overflow)
  );

  typedef struct {
    logic       ss;
    logic       cl;
    logic       lp;
    int         extra;
    logic [7:0] cnt;
    logic [7:0] disp;
    logic       run;
    logic       ovf;
  } vec_t;

  vec_t vecs[27];

  task automatic chk(input string nm, input int idx,
                     input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s[%0d] got %h expected %h", nm, idx, act, exp);
  endtask

  task automatic check_all(input int idx, input logic [7:0] c,
                           input logic [7:0] d, input logic r,
                           input logic o);
    chk("count", idx, count, c);
    chk("display", idx, display, d);
    chk("running", idx, {7'd0, running}, {7'd0, r});
    chk("overflow", idx, {7'd0, overflow}, {7'd0, o});
  endtask

  // One command cycle, then 'extra' idle cycles; ends #1 after an edge.
  task automatic step(input logic ss, input logic cl, input logic lp,
                      input int extra);
    start_stop = ss;
    clear      = cl;
    lap        = lp;
    @(posedge clk);
    #1;
    start_stop = 1'b0;
    clear      = 1'b0;
    lap        = 1'b0;
    repeat (extra) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    //          ss  cl  lp  extra cnt    disp   run ovf
    vecs[0]  = '{0, 0, 0, 0,   8'h00, 8'h00, 0, 0};
    vecs[1]  = '{0, 0, 1, 0,   8'h00, 8'h00, 0, 0};
    vecs[2]  = '{1, 0, 0, 0,   8'h00, 8'h00, 1, 0};
    vecs[3]  = '{0, 0, 0, 2,   8'h00, 8'h00, 1, 0};
    vecs[4]  = '{0, 0, 0, 0,   8'h01, 8'h01, 1, 0};
    vecs[5]  = '{0, 0, 0, 35,  8'h10, 8'h10, 1, 0};
    vecs[6]  = '{0, 1, 0, 0,   8'h00, 8'h00, 0, 0};
    vecs[7]  = '{1, 0, 0, 0,   8'h00, 8'h00, 1, 0};
    vecs[8]  = '{0, 0, 0, 11,  8'h03, 8'h03, 1, 0};
    vecs[9]  = '{0, 0, 1, 0,   8'h03, 8'h03, 1, 0};
    vecs[10] = '{0, 0, 0, 15,  8'h07, 8'h03, 1, 0};
    vecs[11] = '{0, 0, 1, 0,   8'h07, 8'h07, 1, 0};
    vecs[12] = '{0, 1, 0, 0,   8'h00, 8'h00, 0, 0};
    vecs[13] = '{1, 0, 0, 0,   8'h00, 8'h00, 1, 0};
    vecs[14] = '{0, 0, 0, 20,  8'h05, 8'h05, 1, 0};
    vecs[15] = '{1, 0, 0, 19,  8'h05, 8'h05, 0, 0};
    vecs[16] = '{1, 0, 0, 0,   8'h05, 8'h05, 1, 0};
    vecs[17] = '{0, 0, 0, 0,   8'h05, 8'h05, 1, 0};
    vecs[18] = '{0, 0, 0, 0,   8'h06, 8'h06, 1, 0};
    vecs[19] = '{1, 1, 0, 0,   8'h00, 8'h00, 0, 0};
    vecs[20] = '{1, 0, 0, 0,   8'h00, 8'h00, 1, 0};
    vecs[21] = '{0, 0, 0, 5,   8'h01, 8'h01, 1, 0};
    vecs[22] = '{0, 1, 0, 0,   8'h00, 8'h00, 0, 0};
    vecs[23] = '{1, 0, 0, 0,   8'h00, 8'h00, 1, 0};
    vecs[24] = '{0, 0, 0, 398, 8'h99, 8'h99, 1, 0};
    vecs[25] = '{0, 0, 0, 0,   8'h00, 8'h00, 1, 1};
    vecs[26] = '{0, 1, 0, 0,   8'h00, 8'h00, 0, 0};

    reset      = 1'b1;
    start_stop = 1'b0;
    clear      = 1'b0;
    lap        = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all(100, 8'h00, 8'h00, 1'b0, 1'b0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      step(vecs[i].ss, vecs[i].cl, vecs[i].lp, vecs[i].extra);
      check_all(i, vecs[i].cnt, vecs[i].disp,
                vecs[i].run, vecs[i].ovf);
    end

    // Run through a wrap, enter LAP, then reset between edges.
    step(1'b1, 1'b0, 1'b0, 405);
    check_all(200, 8'h01, 8'h01, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 5);
    check_all(201, 8'h02, 8'h01, 1'b1, 1'b1);
    #3;
    reset = 1'b1;
    #1;
    check_all(202, 8'h00, 8'h00, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(1'b0, 1'b0, 1'b0, 4);
    check_all(203, 8'h00, 8'h00, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
